// File: rtl/inst_cache_if.sv
// rtl/inst_cache_if.sv - fetcher and memory-controller signal bundle for inst_cache
interface inst_cache_if;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst;
  logic        cache_busy;
  logic        mem_need_inst;
  logic [31:0] mem_pc;
  logic        mem_busy;
  logic        mem_inst_ready;
  logic [31:0] mem_inst;

  // master: fetcher plus memory controller; slave: the cache itself
  modport master (
    output fetch_req, fetch_pc, flush, mem_busy, mem_inst_ready, mem_inst,
    input  inst_valid, inst, cache_busy, mem_need_inst, mem_pc
  );

  modport slave (
    input  fetch_req, fetch_pc, flush, mem_busy, mem_inst_ready, mem_inst,
    output inst_valid, inst, cache_busy, mem_need_inst, mem_pc
  );
endinterface

// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped one-word-per-line instruction cache with miss FSM
// Storage and hit path exist only when INST_CACHE_EN is defined; otherwise every fetch misses.
module inst_cache #(
  parameter int INDEX_W = 4
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rdy_in,
  inst_cache_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic        mem_need_q, mem_need_d;
  logic [31:0] mem_pc_q, mem_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] fill_q, fill_d;

  logic        hit;
  logic [31:0] hit_data;
  logic        fill_en;

  // Only a completion seen in WAIT counts, so a sticky mem_inst_ready is harmless elsewhere.
  assign fill_en = (state_q == WAIT) && !bus.mem_busy && bus.mem_inst_ready;

`ifdef INST_CACHE_EN
  localparam int TAG_W = 30 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];
  logic [INDEX_W-1:0] req_idx;
  logic [INDEX_W-1:0] fill_idx;

  assign req_idx  = bus.fetch_pc[INDEX_W+1:2];
  assign fill_idx = mem_pc_q[INDEX_W+1:2];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == bus.fetch_pc[31:INDEX_W+2]);
  assign hit_data = data_mem[req_idx];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
    end else if (rdy_in && fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_en) begin
      tag_mem[fill_idx]  <= mem_pc_q[31:INDEX_W+2];
      data_mem[fill_idx] <= bus.mem_inst;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d      = state_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    mem_need_d   = mem_need_q;
    mem_pc_d     = mem_pc_q;
    drop_d       = drop_q;
    fill_d       = fill_q;

    case (state_q)
      IDLE: begin
        if (bus.fetch_req && !bus.flush) begin
          if (hit) begin
            inst_valid_d = 1'b1;
            inst_d       = hit_data;
          end else begin
            mem_pc_d   = bus.fetch_pc;
            mem_need_d = 1'b1;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (bus.flush) drop_d = 1'b1;
        if (bus.mem_busy) begin
          mem_need_d = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (bus.flush) drop_d = 1'b1;
        if (fill_en) begin
          fill_d  = bus.mem_inst;
          state_d = RESP;
        end
      end
      RESP: begin
        // A flush now, or one recorded during the miss, swallows the response.
        if (!bus.flush && !drop_q) begin
          inst_valid_d = 1'b1;
          inst_d       = fill_q;
        end
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        mem_need_d = 1'b0;
        drop_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      mem_need_q   <= 1'b0;
      mem_pc_q     <= '0;
      drop_q       <= 1'b0;
      fill_q       <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      mem_need_q   <= mem_need_d;
      mem_pc_q     <= mem_pc_d;
      drop_q       <= drop_d;
      fill_q       <= fill_d;
    end
  end

  assign bus.inst_valid    = inst_valid_q;
  assign bus.inst          = inst_q;
  assign bus.cache_busy    = (state_q != IDLE);
  assign bus.mem_need_inst = mem_need_q;
  assign bus.mem_pc        = mem_pc_q;

endmodule
